grad_descent_update: RTL

- Consumes the per-element central-difference gradient stream of the objective/gradient stage: `valid_objgradf`, `result_objgradf`, `flagover_objgradf`.
- Applies a fixed-step descent update to the identity coefficient vector and writes the new vector back as that stage's `id_objf_in`.
- Drives that stage's active-low restart, counts iterations, and stops on convergence or iteration limit.
- Sits directly downstream of, and in a loop with, the objective/gradient stage.

---
 rtl/grad_descent_update_if.sv | 11 +
 rtl/grad_descent_update.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/grad_descent_update_if.sv
// Gradient word stream from the objective/gradient stage into the descent updater.
interface grad_descent_update_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  grad_valid;
  logic [DATA_WIDTH-1:0] grad_data;
  logic                  grad_last;

  modport master (output grad_valid, grad_data, grad_last);
  modport slave  (input  grad_valid, grad_data, grad_last);
endinterface

// File: rtl/grad_descent_update.sv
// Fixed-step gradient descent on a coefficient vector, looping with the objective/gradient
// stage: restart it, collect one gradient frame, update id_out, repeat until converged or limit.
module grad_descent_update #(
  parameter int          NUM_ELEMENTS   = 50,
  parameter int          DATA_WIDTH     = 64,
  parameter logic [63:0] LR             = 64'h3F50624DD2F1A9FC,
  parameter logic [63:0] TOL            = 64'h3EB0C6F7A0B5ED8D,
  parameter int          MAX_ITER       = 200,
  parameter int          RESTART_CYCLES = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  id_init,
  grad_descent_update_if.slave                     grad,
  output logic                                     obj_rst_n,
  output logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  id_out,
  output logic [7:0]                               iter_count,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     converged,
  output logic                                     err_frame
);

  localparam int IDXW = $clog2(NUM_ELEMENTS + 1);
  localparam int AW   = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RESTART = 3'd1;
  localparam logic [2:0] COLLECT = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] COMMIT  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  // Double multiply, round-to-nearest-even; subnormals flush to zero, Inf/NaN operands pass through.
  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
    logic         sign;
    logic [105:0] prod;
    logic [51:0]  frac;
    logic         guard, sticky, inc;
    logic [62:0]  body;
    int           ex;
    sign = a[63] ^ b[63];
    if (a[62:52] == 11'h7FF) return {sign, a[62:0]};
    if (b[62:52] == 11'h7FF) return {sign, b[62:0]};
    if (a[62:52] == 11'h000 || b[62:52] == 11'h000) return {sign, 63'd0};
    prod = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    ex = int'(a[62:52]) + int'(b[62:52]) - 1023;
    if (prod[105]) begin
      ex++;
      frac = prod[104:53]; guard = prod[52]; sticky = |prod[51:0];
    end else begin
      frac = prod[103:52]; guard = prod[51]; sticky = |prod[50:0];
    end
    if (ex >= 2047) return {sign, 11'h7FF, 52'd0};
    if (ex <= 0) return {sign, 63'd0};
    inc  = guard & (sticky | frac[0]);
    // A rounding carry out of the fraction rolls into the exponent field on its own.
    body = {11'(ex), frac} + 63'(inc);
    return {sign, body};
  endfunction

  // Double add with three guard bits (guard, round, sticky) for round-to-nearest-even.
  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  x, y;
    logic [55:0]  mx, my, sh;
    logic [111:0] wide;
    logic [56:0]  sum;
    logic [62:0]  body;
    logic         inc, found;
    int           ex, d, lz;
    if (a[62:52] == 11'h7FF) return a;
    if (b[62:52] == 11'h7FF) return b;
    if (b[62:52] == 11'h000) return a;
    if (a[62:52] == 11'h000) return b;
    if (a[62:0] >= b[62:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = int'(x[62:52]);
    d  = int'(x[62:52]) - int'(y[62:52]);
    if (d > 60) d = 60;
    mx   = {1'b1, x[51:0], 3'b000};
    my   = {1'b1, y[51:0], 3'b000};
    wide = {my, 56'd0} >> d;
    sh   = {wide[111:57], wide[56] | (|wide[55:0])};
    if (x[63] == y[63]) sum = {1'b0, mx} + {1'b0, sh};
    else                sum = {1'b0, mx} - {1'b0, sh};
    if (sum == 57'd0) return 64'd0;
    if (sum[56]) begin
      sum = {1'b0, sum[56:2], sum[1] | sum[0]};
      ex++;
    end else begin
      lz = 0;
      found = 1'b0;
      for (int i = 55; i >= 0; i--) begin
        if (!found && sum[i]) begin
          lz = 55 - i;
          found = 1'b1;
        end
      end
      sum = sum << lz;
      ex  = ex - lz;
    end
    if (ex <= 0) return {x[63], 63'd0};
    if (ex >= 2047) return {x[63], 11'h7FF, 52'd0};
    inc  = sum[2] & (sum[1] | sum[0] | sum[3]);
    body = {11'(ex), sum[54:3]} + 63'(inc);
    return {x[63], body};
  endfunction

  function automatic logic [63:0] fp_sub(input logic [63:0] a, input logic [63:0] b);
    return fp_add(a, {~b[63], b[62:0]});
  endfunction

  logic [2:0]                               state;
  logic [7:0]                               cnt;
  logic [IDXW-1:0]                          idx, idx_next;
  logic [62:0]                              maxabs;
  logic                                     accept, excess, below_tol;
  logic                                     s1_valid;
  logic [AW-1:0]                            s1_idx;
  logic [63:0]                              s1_p;
  logic [NUM_ELEMENTS-1:0][DATA_WIDTH-1:0]  shadow;

  always_comb begin
    accept    = (state == COLLECT) && grad.grad_valid && (idx < IDXW'(NUM_ELEMENTS));
    excess    = (state == COLLECT) && grad.grad_valid && (idx >= IDXW'(NUM_ELEMENTS));
    idx_next  = accept ? idx + IDXW'(1) : idx;
    below_tol = (maxabs < TOL[62:0]);
    busy      = (state != IDLE) && (state != DONE);
    obj_rst_n = (state == COLLECT) || (state == DRAIN) || (state == COMMIT);
  end

  // Second pipeline stage: the shadow vector only becomes visible through COMMIT.
  always_ff @(posedge clk) begin
    if (rst && s1_valid)
      shadow[s1_idx] <= fp_sub(id_out[s1_idx], s1_p);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      idx        <= '0;
      maxabs     <= '0;
      s1_valid   <= 1'b0;
      s1_idx     <= '0;
      s1_p       <= '0;
      id_out     <= '0;
      iter_count <= 8'd0;
      done       <= 1'b0;
      converged  <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      done     <= 1'b0;
      s1_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            id_out     <= id_init;
            converged  <= 1'b0;
            err_frame  <= 1'b0;
            iter_count <= 8'd0;
            cnt        <= 8'd0;
            state      <= RESTART;
          end
        end
        RESTART: begin
          idx    <= '0;
          maxabs <= '0;
          if (cnt == 8'(RESTART_CYCLES - 1)) state <= COLLECT;
          else cnt <= cnt + 8'd1;
        end
        COLLECT: begin
          if (accept) begin
            s1_valid <= 1'b1;
            s1_idx   <= idx[AW-1:0];
            s1_p     <= fp_mul(LR, grad.grad_data);
            idx      <= idx_next;
            if (grad.grad_data[62:0] > maxabs) maxabs <= grad.grad_data[62:0];
          end
          if (excess) err_frame <= 1'b1;
          // A short frame is abandoned: the shadow vector never reaches id_out.
          if (grad.grad_last) begin
            if (idx_next != IDXW'(NUM_ELEMENTS)) begin
              err_frame <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= 8'd0;
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt == 8'd1) state <= COMMIT;
          else cnt <= cnt + 8'd1;
        end
        COMMIT: begin
          id_out    <= shadow;
          converged <= below_tol;
          cnt       <= 8'd0;
          if (iter_count != 8'hFF) iter_count <= iter_count + 8'd1;
          if (below_tol || ({1'b0, iter_count} + 9'd1 == 9'(MAX_ITER))) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RESTART;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
